plru_state_array: RTL

- Per-set pseudo-LRU tree storage and update engine for a set-associative cache.
- Stores one (num_ways-1)-bit PLRU tree per set.
- Cache controller presents (set index, hit vector) per access. Block returns the victim way on a miss, or echoes the hit way on a hit.
- Writes the updated tree back. Two-stage pipeline, synchronous-read array model, forwarding, flush sweep FSM.

---
 rtl/plru_state_array_pkg.sv | 18 +
 rtl/plru_state_array_if.sv | 27 ++
 rtl/plru_state_array_tree_update.sv | 67 ++++++
 rtl/plru_state_array.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/plru_state_array_pkg.sv
// Shared types and heap-order tree helpers for the PLRU state array.
package plru_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    FLUSH
  } plru_state_t;

  function automatic int unsigned left_child(input int unsigned k);
    return 2 * k + 1;
  endfunction

  function automatic int unsigned right_child(input int unsigned k);
    return 2 * k + 2;
  endfunction

endpackage

// File: rtl/plru_state_array_if.sv
// Request/response bundle between a cache controller (master) and the PLRU array (slave).
interface plru_state_array_if #(
  parameter int unsigned num_ways = 4,
  parameter int unsigned num_sets = 8,
  parameter int unsigned s_way    = $clog2(num_ways),
  parameter int unsigned s_index  = $clog2(num_sets)
);
  logic                req_valid;
  logic                req_ready;
  logic [s_index-1:0]  req_index;
  logic [num_ways-1:0] req_hits;
  logic                resp_valid;
  logic [num_ways-1:0] resp_way;
  logic [s_way-1:0]    resp_way_idx;
  logic                resp_miss;
  logic                resp_err;

  modport master (
    output req_valid, req_index, req_hits,
    input  req_ready, resp_valid, resp_way, resp_way_idx, resp_miss, resp_err
  );

  modport slave (
    input  req_valid, req_index, req_hits,
    output req_ready, resp_valid, resp_way, resp_way_idx, resp_miss, resp_err
  );
endinterface

// File: rtl/plru_state_array_tree_update.sv
// Combinational PLRU lookup/update: picks victim or hit way and returns the updated tree.
module plru_tree_update
  import plru_pkg::*;
#(
  parameter int unsigned num_ways = 4,
  parameter int unsigned s_way    = $clog2(num_ways)
) (
  input  logic [num_ways-2:0] tree,
  input  logic [num_ways-1:0] hits,
  output logic [num_ways-1:0] way,
  output logic [s_way-1:0]    way_idx,
  output logic                miss,
  output logic                err,
  output logic [num_ways-2:0] new_tree
);

  logic [s_way-1:0]    victim_idx;
  logic [s_way-1:0]    hit_idx;
  logic [s_way-1:0]    upd_idx;
  logic [num_ways-2:0] walked_tree;

  always_comb begin : victim_walk
    int unsigned node;
    node       = 0;
    victim_idx = '0;
    for (int unsigned lvl = 0; lvl < s_way; lvl++) begin
      victim_idx[s_way-1-lvl] = tree[node[s_way-1:0]];
      node = tree[node[s_way-1:0]] ? right_child(node) : left_child(node);
    end
  end

  always_comb begin : hit_encode
    hit_idx = '0;
    for (int unsigned i = 0; i < num_ways; i++) begin
      if (hits[i]) hit_idx = s_way'(i);
    end
    err  = |(hits & (hits - 1'b1));
    miss = (hits == '0);
  end

  assign upd_idx = miss ? victim_idx : hit_idx;

  // Every node on the accessed way's path is pointed away from that way.
  always_comb begin : path_update
    int unsigned node;
    logic        dir;
    node        = 0;
    walked_tree = tree;
    for (int unsigned lvl = 0; lvl < s_way; lvl++) begin
      dir = upd_idx[s_way-1-lvl];
      walked_tree[node[s_way-1:0]] = ~dir;
      node = dir ? right_child(node) : left_child(node);
    end
  end

  always_comb begin : outputs
    way      = '0;
    way_idx  = '0;
    new_tree = tree;
    if (!err) begin
      way      = {{(num_ways-1){1'b0}}, 1'b1} << upd_idx;
      way_idx  = upd_idx;
      new_tree = walked_tree;
    end
  end

endmodule

// File: rtl/plru_state_array.sv
// Per-set PLRU tree storage with a two-stage read/update pipeline and flush sweep.
// Optional PLRU_PERF_CNT_EN adds hit/miss counters.
module plru_state_array
  import plru_pkg::*;
#(
  parameter int unsigned num_ways = 4,
  parameter int unsigned num_sets = 8,
  parameter int unsigned s_way    = $clog2(num_ways),
  parameter int unsigned s_index  = $clog2(num_sets)
) (
  input  logic                clk,
  input  logic                rst,
  plru_state_array_if.slave   bus,
  input  logic                flush,
  output logic                flush_done
`ifdef PLRU_PERF_CNT_EN
  ,
  output logic [31:0]         hit_count,
  output logic [31:0]         miss_count
`endif
);

  localparam int unsigned tw = num_ways - 1;
  localparam logic [s_index-1:0] last_set = s_index'(num_sets - 1);

  plru_state_t         state_q, state_d;
  logic [s_index-1:0]  cnt_q, cnt_d;

  logic                s2_valid_q, s2_valid_d;
  logic [s_index-1:0]  s2_index_q, s2_index_d;
  logic [num_ways-1:0] s2_hits_q, s2_hits_d;
  logic [tw-1:0]       s2_tree_q, s2_tree_d;

  logic [tw-1:0]       array_q [num_sets];
  logic [tw-1:0]       array_d [num_sets];

  logic                accept;
  logic                flush_we;
  logic                wr_en;

  logic [num_ways-1:0] upd_way;
  logic [s_way-1:0]    upd_way_idx;
  logic                upd_miss;
  logic                upd_err;
  logic [tw-1:0]       upd_tree;

  plru_tree_update #(
    .num_ways (num_ways),
    .s_way    (s_way)
  ) u_tree_update (
    .tree     (s2_tree_q),
    .hits     (s2_hits_q),
    .way      (upd_way),
    .way_idx  (upd_way_idx),
    .miss     (upd_miss),
    .err      (upd_err),
    .new_tree (upd_tree)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin : fsm_next
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE:  if (flush) state_d = DRAIN;
      DRAIN: begin
        state_d = FLUSH;
        cnt_d   = '0;
      end
      FLUSH: begin
        if (cnt_q == last_set) state_d = IDLE;
        else                   cnt_d   = cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // A flush pulse wins over a coincident request even though ready is high that cycle.
  always_comb begin : fsm_out
    bus.req_ready = (state_q == IDLE);
    accept        = bus.req_valid && (state_q == IDLE) && !flush;
    flush_we      = (state_q == FLUSH);
    flush_done    = flush_we && (cnt_q == last_set);
  end

  assign wr_en = s2_valid_q && !upd_err;

  always_comb begin : datapath
    s2_valid_d = accept;
    s2_index_d = s2_index_q;
    s2_hits_d  = s2_hits_q;
    s2_tree_d  = s2_tree_q;
    if (accept) begin
      s2_index_d = bus.req_index;
      s2_hits_d  = bus.req_hits;
      if (wr_en && (s2_index_q == bus.req_index)) s2_tree_d = upd_tree;
      else                                        s2_tree_d = array_q[bus.req_index];
    end
    array_d = array_q;
    if (wr_en)    array_d[s2_index_q] = upd_tree;
    if (flush_we) array_d[cnt_q]      = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      s2_index_q <= '0;
      s2_hits_q  <= '0;
      s2_tree_q  <= '0;
      for (int unsigned i = 0; i < num_sets; i++) array_q[i] <= '0;
    end else begin
      s2_valid_q <= s2_valid_d;
      s2_index_q <= s2_index_d;
      s2_hits_q  <= s2_hits_d;
      s2_tree_q  <= s2_tree_d;
      array_q    <= array_d;
    end
  end

  always_comb begin : resp_out
    bus.resp_valid   = s2_valid_q;
    bus.resp_way     = s2_valid_q ? upd_way : '0;
    bus.resp_way_idx = s2_valid_q ? upd_way_idx : '0;
    bus.resp_miss    = s2_valid_q && !upd_err && upd_miss;
    bus.resp_err     = s2_valid_q && upd_err;
  end

`ifdef PLRU_PERF_CNT_EN
  logic [31:0] hit_count_q, hit_count_d;
  logic [31:0] miss_count_q, miss_count_d;

  always_comb begin : perf_next
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    if (wr_en) begin
      if (upd_miss) miss_count_d = miss_count_q + 32'd1;
      else          hit_count_d  = hit_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif

endmodule
